sobel_gradient_pipe: RTL and testbench

Pipelined, parametrised Sobel gradient engine that takes one 3x3 pixel window per accepted transfer and produces signed horizontal and vertical gradients, a selectable magnitude, and an optional edge flag. It supersedes the standalone vertical-gradient block. It sits between the window-buffer stage and the edge-map writer. Both sides use valid/ready handshakes, and the pipeline stalls fully under backpressure.

---
 rtl/sobel_pkg.sv | 32 +++
 rtl/sobel_mag_sel.sv | 34 +++
 rtl/sobel_gradient_pipe.sv | 128 ++++++++++++
 tb/tb_sobel_gradient_pipe.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types, window indices and width helpers for the Sobel gradient pipeline.
package sobel_pkg;

  typedef enum logic [1:0] {
    MAG_L1  = 2'b00,
    MAG_GX  = 2'b01,
    MAG_GY  = 2'b10,
    MAG_MAX = 2'b11
  } mag_mode_e;

  // Row-major 3x3 window positions, P0 = top-left.
  localparam int P0 = 0;
  localparam int P1 = 1;
  localparam int P2 = 2;
  localparam int P3 = 3;
  localparam int P4 = 4;
  localparam int P5 = 5;
  localparam int P6 = 6;
  localparam int P7 = 7;
  localparam int P8 = 8;

  // |gx|,|gy| <= 4*(2^pix_w - 1) needs pix_w+2 magnitude bits plus a sign bit.
  function automatic int grad_w(input int pix_w);
    return pix_w + 3;
  endfunction

  // |gx|+|gy| <= 8*(2^pix_w - 1) fits in pix_w+3 unsigned bits.
  function automatic int mag_w(input int pix_w);
    return pix_w + 3;
  endfunction

endpackage

// File: rtl/sobel_mag_sel.sv
// Combinational absolute value of gx/gy and magnitude select (L1, |gx|, |gy|, max).
module sobel_mag_sel
  import sobel_pkg::*;
#(
  parameter int GRAD_W = 11,
  parameter int MAG_W  = 11
) (
  input  logic signed [GRAD_W-1:0] gx,
  input  logic signed [GRAD_W-1:0] gy,
  input  mag_mode_e                mode,
  output logic        [MAG_W-1:0]  mag
);

  logic [MAG_W-1:0] abs_gx;
  logic [MAG_W-1:0] abs_gy;

  // The most negative gradient is -4*(2^PIX_W-1), never the type minimum,
  // so a plain two's-complement negate is always exact.
  assign abs_gx = gx[GRAD_W-1] ? MAG_W'(-gx) : MAG_W'(gx);
  assign abs_gy = gy[GRAD_W-1] ? MAG_W'(-gy) : MAG_W'(gy);

  always_comb begin
    // NOTE: default assigned before the case so every path drives mag; no latch is inferred.
    mag = '0;
    unique case (mode)
      MAG_L1:  mag = abs_gx + abs_gy;
      MAG_GX:  mag = abs_gx;
      MAG_GY:  mag = abs_gy;
      MAG_MAX: mag = (abs_gx > abs_gy) ? abs_gx : abs_gy;
      default: mag = '0;
    endcase
  end

endmodule

// File: rtl/sobel_gradient_pipe.sv
// Three-stage Sobel gradient engine with global-stall valid/ready handshake.
// Define SOBEL_THRESH_EN to build the threshold path; otherwise edge_flag is tied 0.
module sobel_gradient_pipe
  import sobel_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int GRAD_W = grad_w(PIX_W),
  parameter int MAG_W  = mag_w(PIX_W)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [9*PIX_W-1:0]       window,
  input  logic [1:0]               mode,
  input  logic [MAG_W-1:0]         thresh,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [GRAD_W-1:0] gx,
  output logic signed [GRAD_W-1:0] gy,
  output logic [MAG_W-1:0]         mag,
  output logic                     edge_flag
);

  localparam int SUM_W = PIX_W + 2;

  function automatic logic [SUM_W-1:0] tri_sum(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b,
                                                input logic [PIX_W-1:0] c);
    return SUM_W'(a) + (SUM_W'(b) << 1) + SUM_W'(c);
  endfunction

  logic [PIX_W-1:0] pix [9];

  always_comb begin
    for (int i = 0; i < 9; i++) pix[i] = window[i*PIX_W +: PIX_W];
  end

  logic adv;
  logic s1_valid, s2_valid, s3_valid;

  logic [SUM_W-1:0] s1_top, s1_bot, s1_right, s1_left;
  mag_mode_e        s1_mode, s2_mode;

  logic signed [GRAD_W-1:0] s2_gx, s2_gy;
  logic [MAG_W-1:0]         mag_d;

  // One stall signal freezes every stage, so nothing can be dropped or duplicated.
  assign adv       = out_ready | ~s3_valid;
  assign in_ready  = adv;
  assign out_valid = s3_valid;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so each stage samples the previous stage's pre-edge value.
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
    end
  end

  // NOTE: S1/S2 datapath registers are not reset; the stage valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_top   <= tri_sum(pix[P0], pix[P1], pix[P2]);
      s1_bot   <= tri_sum(pix[P6], pix[P7], pix[P8]);
      s1_right <= tri_sum(pix[P2], pix[P5], pix[P8]);
      s1_left  <= tri_sum(pix[P0], pix[P3], pix[P6]);
      s1_mode  <= mag_mode_e'(mode);

      s2_gx   <= GRAD_W'(s1_right) - GRAD_W'(s1_left);
      s2_gy   <= GRAD_W'(s1_top) - GRAD_W'(s1_bot);
      s2_mode <= s1_mode;
    end
  end

  sobel_mag_sel #(
    .GRAD_W (GRAD_W),
    .MAG_W  (MAG_W)
  ) u_mag_sel (
    .gx   (s2_gx),
    .gy   (s2_gy),
    .mode (s2_mode),
    .mag  (mag_d)
  );

  // Output stage is reset so the result bus reads zero until the first window lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      gx  <= '0;
      gy  <= '0;
      mag <= '0;
    end else if (adv) begin
      gx  <= s2_gx;
      gy  <= s2_gy;
      mag <= mag_d;
    end
  end

`ifdef SOBEL_THRESH_EN
  logic [MAG_W-1:0] s1_thresh, s2_thresh;

  always_ff @(posedge clk) begin
    if (adv) begin
      s1_thresh <= thresh;
      s2_thresh <= s1_thresh;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      edge_flag <= 1'b0;
    end else if (adv) begin
      edge_flag <= (mag_d > s2_thresh);
    end
  end
`else
  logic unused_thresh;

  assign unused_thresh = ^thresh;
  assign edge_flag     = 1'b0;
`endif

endmodule

// File: tb/tb_sobel_gradient_pipe.sv
// Self-checking bench: directed literal cases, backpressure, mid-stream reset and
// randomized traffic scored against a queue-based behavioural model.
module tb_sobel_gradient_pipe;

  localparam int PIX_W = 8;
  localparam int GRAD_W = PIX_W + 3;
  localparam int MAG_W = PIX_W + 3;
  localparam int PMAX = (1 << PIX_W) - 1;
`ifdef SOBEL_THRESH_EN
  localparam int THR_EN = 1;
`else
  localparam int THR_EN = 0;
`endif

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic [9*PIX_W-1:0]       window = '0;
  logic [1:0]               mode = 2'b00;
  logic [MAG_W-1:0]         thresh = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b1;
  logic signed [GRAD_W-1:0] gx;
  logic signed [GRAD_W-1:0] gy;
  logic [MAG_W-1:0]         mag;
  logic                     edge_flag;

  always #5 clk = ~clk;

  sobel_gradient_pipe #(.PIX_W(PIX_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .window    (window),
    .mode      (mode),
    .thresh    (thresh),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .gx        (gx),
    .gy        (gy),
    .mag       (mag),
    .edge_flag (edge_flag)
  );

  typedef struct {
    int gx;
    int gy;
    int mag;
    int edge_f;
  } res_t;

  res_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic res_t model(input logic [9*PIX_W-1:0] w, input logic [1:0] m, input int t);
    int   p[9];
    int   ax, ay;
    res_t r;
    for (int i = 0; i < 9; i++) p[i] = int'(w[i*PIX_W +: PIX_W]);
    r.gy = (p[0] + 2*p[1] + p[2]) - (p[6] + 2*p[7] + p[8]);
    r.gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
    ax = (r.gx < 0) ? -r.gx : r.gx;
    ay = (r.gy < 0) ? -r.gy : r.gy;
    case (m)
      2'd0:    r.mag = ax + ay;
      2'd1:    r.mag = ax;
      2'd2:    r.mag = ay;
      default: r.mag = (ax > ay) ? ax : ay;
    endcase
    r.edge_f = (THR_EN != 0 && r.mag > t) ? 1 : 0;
    return r;
  endfunction

  function automatic logic [9*PIX_W-1:0] pack9(input int p[9]);
    logic [9*PIX_W-1:0] w;
    w = '0;
    for (int i = 0; i < 9; i++) w[i*PIX_W +: PIX_W] = PIX_W'(p[i]);
    return w;
  endfunction

  function automatic logic [9*PIX_W-1:0] rand_win();
    int p[9];
    for (int i = 0; i < 9; i++) begin
      case ($urandom_range(0, 3))
        0:       p[i] = 0;
        1:       p[i] = PMAX;
        default: p[i] = int'($urandom_range(0, PMAX));
      endcase
    end
    return pack9(p);
  endfunction

  // Scoreboard: every cycle the outputs are meaningful they must match the oldest pending result.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        check("pending_result", (exp_q.size() != 0) ? 1 : 0, 1);
        if (exp_q.size() != 0) begin
          check("sb_gx", $signed(gx), exp_q[0].gx);
          check("sb_gy", $signed(gy), exp_q[0].gy);
          check("sb_mag", mag, exp_q[0].mag);
          check("sb_edge", edge_flag, exp_q[0].edge_f);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(window, mode, int'(thresh)));
    end
  end

  task automatic directed(input string name, input logic [9*PIX_W-1:0] w, input logic [1:0] m,
                          input int t, input int egx, input int egy, input int emag,
                          input int eedge);
    int lat;
    @(posedge clk);
    #1;
    window    = w;
    mode      = m;
    thresh    = MAG_W'(t);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check({name, "_in_ready"}, in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    check({name, "_latency"}, lat, 3);
    check({name, "_gx"}, $signed(gx), egx);
    check({name, "_gy"}, $signed(gy), egy);
    check({name, "_mag"}, mag, emag);
    check({name, "_edge"}, edge_flag, eedge);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pv[9];
    logic [9*PIX_W-1:0] w_flat, w_vert, w_vneg, w_top, w_diag;
    logic [9*PIX_W-1:0] bp_w[6];
    int sent, got;

    pv = '{100, 100, 100, 100, 100, 100, 100, 100, 100};
    w_flat = pack9(pv);
    pv = '{0, 128, 255, 0, 128, 255, 0, 128, 255};
    w_vert = pack9(pv);
    pv = '{255, 128, 0, 255, 128, 0, 255, 128, 0};
    w_vneg = pack9(pv);
    pv = '{255, 255, 255, 0, 0, 0, 0, 0, 0};
    w_top = pack9(pv);
    pv = '{255, 255, 255, 0, 0, 255, 0, 0, 255};
    w_diag = pack9(pv);

    // Reset state
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_gx", $signed(gx), 0);
    check("rst_gy", $signed(gy), 0);
    check("rst_mag", mag, 0);
    check("rst_edge", edge_flag, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    // Hand-computed literal cases
    directed("flat", w_flat, 2'b00, 0, 0, 0, 0, 0);
    directed("vert_l1", w_vert, 2'b00, 2047, 1020, 0, 1020, 0);
    directed("vneg_gx", w_vneg, 2'b01, 2047, -1020, 0, 1020, 0);
    directed("top_gy", w_top, 2'b10, 2047, 0, 1020, 1020, 0);
    directed("diag_l1", w_diag, 2'b00, 2047, 765, 765, 1530, 0);
    directed("diag_max", w_diag, 2'b11, 2047, 765, 765, 765, 0);
    directed("thr_eq", w_vert, 2'b00, 1020, 1020, 0, 1020, 0);
    directed("thr_below", w_vert, 2'b00, 1019, 1020, 0, 1020, THR_EN);

    // Backpressure: six back-to-back windows, out_ready low for cycles 4..8
    for (int i = 0; i < 6; i++) bp_w[i] = rand_win();
    sent = 0;
    got  = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      @(posedge clk);
      #1;
      out_ready = !(c >= 4 && c <= 8);
      in_valid  = (sent < 6);
      if (sent < 6) begin
        window = bp_w[sent];
        mode   = 2'(sent % 4);
        thresh = MAG_W'(400 * sent);
      end
      @(negedge clk);
      if (c >= 4 && c <= 8) check("bp_in_ready_low", in_ready, 0);
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) got++;
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_sent", sent, 6);
    check("bp_got", got, 6);
    repeat (4) @(posedge clk);

    // Reset with three windows in flight
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      window   = rand_win();
      mode     = 2'(c);
      @(negedge clk);
      check("mid_rst_accept", in_ready, 1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    check("mid_rst_held_valid", out_valid, 1);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_gx", $signed(gx), 0);
    check("mid_rst_gy", $signed(gy), 0);
    check("mid_rst_mag", mag, 0);
    check("mid_rst_edge", edge_flag, 0);
    check("mid_rst_in_ready", in_ready, 1);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("mid_rst_no_stale", out_valid, 0);
    end

    // Randomized traffic with random backpressure
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      window    = rand_win();
      mode      = 2'($urandom_range(0, 3));
      thresh    = MAG_W'($urandom_range(0, 2047));
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("drain_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
